// File: rtl/bkram_pkg.sv
// Shared types and constants for the backup-RAM sector controller.
// Holds the FSM state encoding, transfer kinds and the default format header table.
package bkram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_FORMAT
  } state_t;

  typedef enum logic [1:0] {
    XF_LOAD,
    XF_FULL,
    XF_DIRTY
  } xfer_t;

  localparam int SECTOR_BYTES = 512;

  // Default format header; words past the table read as zero.
  function automatic logic [15:0] fmt_word(input logic [31:0] idx);
    logic [15:0] w;
    w = 16'h0000;
    case (idx)
      32'd0:   w = 16'h5548;
      32'd1:   w = 16'h4D42;
      32'd2:   w = 16'h8800;
      32'd3:   w = 16'h8010;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bkram_sector_ctrl_if.sv
// SD block-request bus between the sector controller (master) and the SD card engine (slave).
// Request is held until sd_ack rises; the sector completes when sd_ack falls again.
interface bkram_sector_ctrl_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/bkram_dirty_map.sv
// Per-sector dirty bitmap with single-bit set/clear, bulk set/clear and a lookup port.
// Updates land one cycle after the request; a set beats a clear of the same bit.
module bkram_dirty_map #(
  parameter int SECTORS = 16,
  parameter int SW      = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          set_en,
  input  logic [SW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [SW-1:0] clr_idx,
  input  logic          clr_all,
  input  logic          set_all,
  input  logic [SW-1:0] q_idx,
  output logic          q_dirty,
  output logic          any_dirty
);

  logic [SECTORS-1:0] map;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      map <= '0;
    end else if (clr_all) begin
      map <= '0;
    end else if (set_all) begin
      map <= '1;
    end else begin
      if (clr_en) map[clr_idx] <= 1'b0;
      // Ordered after the clear so a write landing on a completing sector keeps it dirty.
      if (set_en) map[set_idx] <= 1'b1;
    end
  end

  assign q_dirty   = map[q_idx];
  assign any_dirty = |map;

endmodule

// File: rtl/bkram_sector_ctrl.sv
// Moves the core backup RAM to/from SD sector by sector (load, full save, dirty-only save, format).
// Outputs are registered; each sector waits on the sd_ack rise/fall handshake, no timeout.
module bkram_sector_ctrl
  import bkram_pkg::*;
#(
  parameter int          SECTORS   = 16,
  parameter logic [31:0] LBA_BASE  = 32'd0,
  parameter int          CORE_AW   = 11,
  parameter int          FMT_WORDS = 4
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                bk_ena,
  input  logic                load_req,
  input  logic                save_req,
  input  logic                mount_load,
  input  logic                autosave,
  input  logic                osd_open,
  input  logic                format_req,
  input  logic                core_we,
  input  logic [CORE_AW-1:0]  core_addr,
  bkram_sector_ctrl_if.master sd,
  output logic                busy,
  output logic                loading,
  output logic                pending,
  output logic                fmt_we,
  output logic [((FMT_WORDS > 1) ? $clog2(FMT_WORDS) : 1)-1:0] fmt_addr,
  output logic [15:0]         fmt_data
);

  localparam int LOG2S = $clog2(SECTORS);
  localparam int SW    = (LOG2S > 0) ? LOG2S : 1;
  localparam int FAW   = (FMT_WORDS > 1) ? $clog2(FMT_WORDS) : 1;

  state_t        state;
  xfer_t         xfer;
  logic [SW-1:0] sec;
  logic          load_q, save_q, osd_q, fmt_q, bk_ena_q, ack_block;
  logic          q_dirty, any_dirty;
  logic          load_trig, full_trig, dirty_trig, fmt_trig;
  logic          last_sec, fmt_last, sec_done, bk_fall;
  logic [SW-1:0] core_sec;

  assign core_sec   = SW'(core_addr >> (CORE_AW - LOG2S));
  assign load_trig  = ((load_req & ~load_q) | mount_load) & bk_ena;
  assign full_trig  = save_req & ~save_q & bk_ena;
  assign dirty_trig = osd_open & ~osd_q & autosave & pending;
  assign fmt_trig   = format_req & ~fmt_q;
  assign last_sec   = (sec == SW'(SECTORS - 1));
  assign fmt_last   = (fmt_addr == FAW'(FMT_WORDS - 1));
  assign sec_done   = (state == ST_WAIT_LO) && !sd.sd_ack;
  assign bk_fall    = bk_ena_q & ~bk_ena;

  bkram_dirty_map #(.SECTORS(SECTORS), .SW(SW)) u_map (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .set_en    (core_we & bk_ena),
    .set_idx   (core_sec),
    .clr_en    (sec_done && (xfer != XF_LOAD)),
    .clr_idx   (sec),
    .clr_all   ((sec_done && (xfer == XF_LOAD) && last_sec) || bk_fall),
    .set_all   ((state == ST_FORMAT) && fmt_last),
    .q_idx     (sec),
    .q_dirty   (q_dirty),
    .any_dirty (any_dirty)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      xfer      <= XF_LOAD;
      sec       <= '0;
      sd.sd_rd  <= 1'b0;
      sd.sd_wr  <= 1'b0;
      sd.sd_lba <= LBA_BASE;
      busy      <= 1'b0;
      loading   <= 1'b0;
      pending   <= 1'b0;
      fmt_we    <= 1'b0;
      fmt_addr  <= '0;
      fmt_data  <= '0;
      load_q    <= load_req;
      save_q    <= save_req;
      osd_q     <= osd_open;
      fmt_q     <= format_req;
      bk_ena_q  <= bk_ena;
      // An ack left over from an aborted transfer must fall before it counts again.
      ack_block <= sd.sd_ack;
    end else begin
      load_q   <= load_req;
      save_q   <= save_req;
      osd_q    <= osd_open;
      fmt_q    <= format_req;
      bk_ena_q <= bk_ena;
      pending  <= bk_ena & any_dirty;
      if (!sd.sd_ack) ack_block <= 1'b0;

      case (state)
        ST_IDLE: begin
          sec <= '0;
          if (load_trig) begin
            xfer <= XF_LOAD; loading <= 1'b1; busy <= 1'b1; state <= ST_ISSUE;
          end else if (full_trig) begin
            xfer <= XF_FULL; busy <= 1'b1; state <= ST_ISSUE;
          end else if (dirty_trig) begin
            xfer <= XF_DIRTY; busy <= 1'b1; state <= ST_ISSUE;
          end else if (fmt_trig) begin
            busy     <= 1'b1;
            fmt_we   <= 1'b1;
            fmt_addr <= '0;
            fmt_data <= fmt_word(32'd0);
            state    <= ST_FORMAT;
          end
        end
        ST_ISSUE: begin
          if (xfer == XF_DIRTY && !q_dirty) begin
            if (last_sec) begin
              state <= ST_IDLE; busy <= 1'b0;
            end else begin
              sec <= sec + SW'(1);
            end
          end else begin
            sd.sd_lba <= LBA_BASE + 32'(sec);
            sd.sd_rd  <= (xfer == XF_LOAD);
            sd.sd_wr  <= (xfer != XF_LOAD);
            state     <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (sd.sd_ack && !ack_block) begin
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
            state    <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!sd.sd_ack) begin
            if (last_sec) begin
              state <= ST_IDLE; busy <= 1'b0; loading <= 1'b0;
            end else begin
              sec   <= sec + SW'(1);
              state <= ST_ISSUE;
            end
          end
        end
        ST_FORMAT: begin
          if (fmt_last) begin
            fmt_we <= 1'b0; busy <= 1'b0; state <= ST_IDLE;
          end else begin
            fmt_addr <= fmt_addr + FAW'(1);
            fmt_data <= fmt_word(32'(fmt_addr) + 32'd1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
